// File: rtl/eth_rx_arb_pkg.sv
// Shared types and widths for the Ethernet RX stream arbiter.
package eth_rx_arb_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = 64;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/eth_rx_stream_arbiter_if.sv
// Stream bundle between the per-port RX FIFOs, the arbiter and the merged consumer.
interface eth_rx_stream_arbiter_if
  import eth_rx_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
);

  logic [NUM_PORTS-1:0]        s_tvalid;
  logic [NUM_PORTS-1:0]        s_tready;
  logic [NUM_PORTS*DATA_W-1:0] s_tdata;
  logic [NUM_PORTS*KEEP_W-1:0] s_tkeep;
  logic [NUM_PORTS-1:0]        s_tlast;

  logic                        m_tvalid;
  logic                        m_tready;
  logic [DATA_W-1:0]           m_tdata;
  logic [KEEP_W-1:0]           m_tkeep;
  logic                        m_tlast;
  logic [PORT_W-1:0]           m_tid;

  // Environment side: feeds the input streams and drains the merged stream.
  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid
  );

  // Arbiter side.
  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid
  );

endinterface

// File: rtl/eth_rx_rr_pick.sv
// Combinational round-robin picker: first set request bit after 'last', wrapping.
module eth_rx_rr_pick #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic                 found,
  output logic [PORT_W-1:0]    idx
);

  int unsigned p;

  // Scan last+1 .. last+NUM_PORTS so the previous winner is checked last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      p = (32'(last) + k) % NUM_PORTS;
      if (!found && req[p]) begin
        found = 1'b1;
        idx   = PORT_W'(p);
      end
    end
  end

endmodule

// File: rtl/eth_rx_stream_arbiter.sv
// Frame-granular round-robin merge of per-port 512-bit RX streams onto one output.
module eth_rx_stream_arbiter
  import eth_rx_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  eth_rx_stream_arbiter_if.slave     bus,
  input  logic [NUM_PORTS-1:0]       port_en,
  output logic [NUM_PORTS*CNT_W-1:0] dbg_frames
);

  arb_state_e           state;
  logic [PORT_W-1:0]    gnt;
  logic [PORT_W-1:0]    last;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] ready;
  logic                 pick_found;
  logic [PORT_W-1:0]    pick_idx;
  logic                 can_load;
  logic                 accept;
  logic                 last_acc;
  logic                 arb_event;

  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [KEEP_W-1:0]    out_keep;
  logic                 out_last;
  logic [PORT_W-1:0]    out_tid;

  assign req       = bus.s_tvalid & port_en;
  assign can_load  = !out_valid || bus.m_tready;
  assign accept    = (state == BUSY) && can_load && bus.s_tvalid[gnt];
  assign last_acc  = accept && bus.s_tlast[gnt];
  // Re-arbitrating in the tlast cycle is what makes back-to-back frames bubble-free.
  assign arb_event = (state == IDLE) || last_acc;

  eth_rx_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the granted port sees ready, and only when the output register can take a beat.
  always_comb begin
    ready = '0;
    if (state == BUSY && can_load) begin
      ready[gnt] = 1'b1;
    end
  end

  // Grant FSM plus the registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= PORT_W'(NUM_PORTS - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_tid   <= '0;
    end else begin
      if (arb_event) begin
        if (pick_found) begin
          state <= BUSY;
          gnt   <= pick_idx;
          last  <= pick_idx;
        end else begin
          state <= IDLE;
        end
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= bus.s_tdata[32'(gnt) * DATA_W +: DATA_W];
        out_keep  <= bus.s_tkeep[32'(gnt) * KEEP_W +: KEEP_W];
        out_last  <= bus.s_tlast[gnt];
        out_tid   <= gnt;
      end else if (bus.m_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    // Count frames whose tlast beat has been taken from this port; wraps naturally.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (last_acc && (gnt == PORT_W'(i))) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign dbg_frames[i*CNT_W +: CNT_W] = cnt;
  end

  assign bus.s_tready = ready;
  assign bus.m_tvalid = out_valid;
  assign bus.m_tdata  = out_data;
  assign bus.m_tkeep  = out_keep;
  assign bus.m_tlast  = out_last;
  assign bus.m_tid    = out_tid;

endmodule

// File: tb/tb_eth_rx_stream_arbiter.sv
// Self-checking bench: frame-level round-robin model driving a beat scoreboard.
module tb_eth_rx_stream_arbiter;
  import eth_rx_arb_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned PW = 2;

  typedef struct {
    logic [511:0]  data;
    logic [63:0]   keep;
    logic          last;
    logic [PW-1:0] tid;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_en;
  logic [NP*32-1:0]  dbg_frames;

  eth_rx_stream_arbiter_if #(.NUM_PORTS(NP), .PORT_W(PW)) bus ();

  eth_rx_stream_arbiter #(.NUM_PORTS(NP), .PORT_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .port_en    (port_en),
    .dbg_frames (dbg_frames)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks;
  int unsigned   n_errors;
  beat_t         pq [NP][$];
  beat_t         exp_q [$];
  logic [31:0]   exp_cnt [NP];
  int            fo;
  logic [NP-1:0] m;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = {$urandom, $urandom};
      b.last = (i == len - 1);
      b.tid  = PW'(p);
      pq[p].push_back(b);
    end
  endtask

  // Frame-level round robin over ports that still hold frames and are enabled.
  task automatic build_expect(input logic [NP-1:0] en_first, input logic [NP-1:0] en_rest);
    int            ptr [NP];
    int            lst;
    int            w;
    int            q;
    logic [NP-1:0] en;
    beat_t         b;
    for (int p = 0; p < NP; p++) ptr[p] = 0;
    lst = NP - 1;
    en  = en_first;
    forever begin
      w = -1;
      for (int k = 1; k <= NP; k++) begin
        q = (lst + k) % NP;
        if (w < 0 && en[q] && ptr[q] < pq[q].size()) w = q;
      end
      if (w < 0) break;
      do begin
        b = pq[w][ptr[w]];
        exp_q.push_back(b);
        ptr[w]++;
      end while (!b.last);
      exp_cnt[w] = exp_cnt[w] + 32'd1;
      lst = w;
      en  = en_rest;
    end
  endtask

  task automatic drive_inputs(input bit rnd_ready);
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() != 0) begin
        bus.s_tvalid[p]            = 1'b1;
        bus.s_tdata[p*512 +: 512]  = pq[p][0].data;
        bus.s_tkeep[p*64 +: 64]    = pq[p][0].keep;
        bus.s_tlast[p]             = pq[p][0].last;
      end else begin
        bus.s_tvalid[p]            = 1'b0;
        bus.s_tdata[p*512 +: 512]  = '0;
        bus.s_tkeep[p*64 +: 64]    = '0;
        bus.s_tlast[p]             = 1'b0;
      end
    end
    bus.m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      pq[p].delete();
      exp_cnt[p] = '0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    port_en = '1;
    clear_model();
    drive_inputs(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_counters();
    for (int p = 0; p < NP; p++)
      check($sformatf("frames%0d", p), dbg_frames[p*32 +: 32], exp_cnt[p]);
  endtask

  // One sample per cycle at negedge+1: inputs for the coming edge are already applied.
  task automatic run_phase(input bit rnd_ready, input int clr_en0_after, input int rst_port,
                           input int rst_after, input bit chk_gap, output int first_out);
    int    cyc;
    int    last_out;
    int    extra;
    int    nbeats;
    int    acc [NP];
    bit    stalled;
    bit    aborted;
    beat_t prev;
    beat_t b;
    cyc = 0; last_out = -1; extra = 0; stalled = 0; aborted = 0;
    first_out = -1;
    nbeats = exp_q.size();
    for (int p = 0; p < NP; p++) acc[p] = 0;
    while (cyc < 600 && extra < 8) begin
      @(negedge clk);
      if (clr_en0_after > 0 && acc[0] >= clr_en0_after) port_en[0] = 1'b0;
      drive_inputs(rnd_ready);
      #1;
      if (stalled) begin
        check("stall_valid", bus.m_tvalid, 1);
        check("stall_data", bus.m_tdata, prev.data);
        check("stall_keep", bus.m_tkeep, prev.keep);
        check("stall_last", bus.m_tlast, prev.last);
        check("stall_tid", bus.m_tid, prev.tid);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("out_data", bus.m_tdata, b.data);
          check("out_keep", bus.m_tkeep, b.keep);
          check("out_last", bus.m_tlast, b.last);
          check("out_tid", bus.m_tid, b.tid);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      stalled   = bus.m_tvalid && !bus.m_tready;
      prev.data = bus.m_tdata;
      prev.keep = bus.m_tkeep;
      prev.last = bus.m_tlast;
      prev.tid  = bus.m_tid;
      for (int p = 0; p < NP; p++) begin
        if (bus.s_tvalid[p] && bus.s_tready[p]) begin
          void'(pq[p].pop_front());
          acc[p]++;
        end
      end
      if (rst_after > 0 && acc[rst_port] >= rst_after) begin
        aborted = 1;
        break;
      end
      if (exp_q.size() == 0) extra++;
      cyc++;
    end
    if (!aborted) begin
      check("drain", exp_q.size(), 0);
      if (chk_gap) check("no_bubble", last_out - first_out, nbeats - 1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    do_reset();
    #1;
    check("rst_m_tvalid", bus.m_tvalid, 0);
    check("rst_m_tdata", bus.m_tdata, 0);
    check("rst_m_tkeep", bus.m_tkeep, 0);
    check("rst_m_tlast", bus.m_tlast, 0);
    check("rst_m_tid", bus.m_tid, 0);
    check("rst_s_tready", bus.s_tready, 0);
    check("rst_dbg_frames", dbg_frames, 0);

    // First grant, latency and back-to-back frames
    add_frame(0, 3);
    add_frame(1, 3);
    build_expect('1, '1);
    run_phase(0, 0, 0, 0, 1, fo);
    check("first_latency", fo, 2);
    check_counters();

    // Fairness with single-beat frames on every port
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < NP; p++) add_frame(p, 1);
    build_expect('1, '1);
    run_phase(0, 0, 0, 0, 1, fo);
    check_counters();

    // Random traffic, random masks, random backpressure
    for (int r = 0; r < 4; r++) begin
      do_reset();
      m = (r == 0) ? '1 : NP'($urandom_range(1, (1 << NP) - 1));
      port_en = m;
      if (r == 0) add_frame(0, 5);
      for (int p = 0; p < NP; p++)
        repeat ($urandom_range(0, 3)) add_frame(p, $urandom_range(1, 5));
      build_expect(m, m);
      run_phase(1, 0, 0, 0, 0, fo);
      check_counters();
    end

    // Enable cleared mid-frame
    do_reset();
    add_frame(0, 4);
    add_frame(0, 1);
    add_frame(1, 2);
    add_frame(1, 2);
    build_expect('1, 3'b110);
    run_phase(0, 1, 0, 0, 1, fo);
    check_counters();

    // Counter wrap on port 1
    do_reset();
    @(negedge clk);
    force dut.g_cnt[1].cnt = 32'hFFFF_FFFF;
    #1;
    release dut.g_cnt[1].cnt;
    #1;
    check("wrap_preload", dbg_frames[32 +: 32], 32'hFFFF_FFFF);
    exp_cnt[1] = 32'hFFFF_FFFF;
    add_frame(1, 2);
    build_expect('1, '1);
    run_phase(1, 0, 0, 0, 0, fo);
    check_counters();

    // Reset during beat 2 of a frame, then priority returns to port 0
    do_reset();
    add_frame(1, 3);
    build_expect('1, '1);
    run_phase(0, 0, 1, 1, 0, fo);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_m_tvalid", bus.m_tvalid, 0);
    check("midrst_s_tready", bus.s_tready, 0);
    rst = 1'b0;
    clear_model();
    drive_inputs(1'b0);
    add_frame(1, 2);
    add_frame(0, 2);
    build_expect('1, '1);
    run_phase(0, 0, 0, 0, 1, fo);
    check_counters();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
